// File: rtl/mul_pkg.sv
// Shared widths and payload types for the multiplier normalisation path.
package mul_pkg;

    localparam int EXPO_W = 8;
    localparam int MANT_W = 23;
    localparam int ZERO_D = 6;
    localparam int TAG_W  = 4;
    localparam int PROD_W = 2 * MANT_W + 2;

    typedef struct packed {
        logic [EXPO_W+1:0] expo;
        logic [PROD_W-1:0] mant;
    } mul_prod_t;

    typedef struct packed {
        logic [EXPO_W+1:0] expo;
        logic [PROD_W-1:0] mant;
        logic              bit_s;
    } mul_norm_t;

endpackage

// File: rtl/mul_lzc.sv
// Combinational leading-zero counter; an all-zero input reports IN_W.
module mul_lzc
    import mul_pkg::*;
#(
    parameter int IN_W  = PROD_W,
    parameter int OUT_W = ZERO_D
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] cnt
);

    logic [OUT_W-1:0] cnt_s;

    // Scan upward so the highest set bit is the last one to overwrite the count.
    always_comb begin
        cnt_s = OUT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            cnt_s = din[i] ? OUT_W'(IN_W - 1 - i) : cnt_s;
        end
    end

    assign cnt = cnt_s;

endmodule

// File: rtl/mul_shift_arb.sv
// Two-requester round-robin front end for a shared post-normalisation shift stage,
// with a stage-1 register feeding the shift stage and a registered result slot.
module mul_shift_arb #(
    parameter int EXPO_W = mul_pkg::EXPO_W,
    parameter int MANT_W = mul_pkg::MANT_W,
    parameter int ZERO_D = mul_pkg::ZERO_D,
    parameter int TAG_W  = mul_pkg::TAG_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [1:0][EXPO_W+1:0]         req_expo,
    input  logic [1:0][2*MANT_W+1:0]       req_mant,
    input  logic [1:0][TAG_W-1:0]          req_tag,
    output logic [EXPO_W+1:0]              dp_expo_1,
    output logic [2*MANT_W+1:0]            dp_mant_1,
    output logic [ZERO_D-1:0]              dp_zero_nums_c,
    input  logic [EXPO_W+1:0]              dp_expo_2,
    input  logic [2*MANT_W+1:0]            dp_mant_2,
    input  logic                           dp_bit_s,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_id,
    output logic [TAG_W-1:0]               out_tag,
    output logic [EXPO_W+1:0]              out_expo,
    output logic [2*MANT_W+1:0]            out_mant,
    output logic                           out_bit_s,
    output logic                           busy
);

    localparam int EW = EXPO_W + 2;
    localparam int PW = 2 * MANT_W + 2;

    logic [1:0]       grant_s;
    logic             adv_out_s;
    logic             adv_s1_s;
    logic             hs_s;
    logic             hs_id_s;

    logic             last_grant_q, last_grant_d;
    logic             s1_valid_q,   s1_valid_d;
    logic [EW-1:0]    s1_expo_q,    s1_expo_d;
    logic [PW-1:0]    s1_mant_q,    s1_mant_d;
    logic [TAG_W-1:0] s1_tag_q,     s1_tag_d;
    logic             s1_id_q,      s1_id_d;
    logic             out_valid_q,  out_valid_d;
    logic [EW-1:0]    out_expo_q,   out_expo_d;
    logic [PW-1:0]    out_mant_q,   out_mant_d;
    logic             out_bit_s_q,  out_bit_s_d;
    logic             out_id_q,     out_id_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;

    // Round-robin grant and request-side handshake qualification.
    always_comb begin
        grant_s   = 2'b00;
        adv_out_s = !out_valid_q | out_ready;
        adv_s1_s  = !s1_valid_q | adv_out_s;
        case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
        req_ready = grant_s & {2{adv_s1_s & !flush}};
        hs_s      = |(req_valid & req_ready);
        hs_id_s   = req_ready[1];
    end

    // Stage-1 next state; the pointer only moves when a request is actually taken.
    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_expo_d    = s1_expo_q;
        s1_mant_d    = s1_mant_q;
        s1_tag_d     = s1_tag_q;
        s1_id_d      = s1_id_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (hs_s) begin
            s1_valid_d   = 1'b1;
            s1_expo_d    = req_expo[hs_id_s];
            s1_mant_d    = req_mant[hs_id_s];
            s1_tag_d     = req_tag[hs_id_s];
            s1_id_d      = hs_id_s;
            last_grant_d = hs_id_s;
        end else if (adv_s1_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Result slot next state; payload is held when the slot empties.
    always_comb begin
        out_valid_d = out_valid_q;
        out_expo_d  = out_expo_q;
        out_mant_d  = out_mant_q;
        out_bit_s_d = out_bit_s_q;
        out_id_d    = out_id_q;
        out_tag_d   = out_tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s1_valid_q & adv_out_s) begin
            out_valid_d = 1'b1;
            out_expo_d  = dp_expo_2;
            out_mant_d  = dp_mant_2;
            out_bit_s_d = dp_bit_s;
            out_id_d    = s1_id_q;
            out_tag_d   = s1_tag_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_expo_q    <= '0;
            s1_mant_q    <= '0;
            s1_tag_q     <= '0;
            s1_id_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_expo_q   <= '0;
            out_mant_q   <= '0;
            out_bit_s_q  <= 1'b0;
            out_id_q     <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_expo_q    <= s1_expo_d;
            s1_mant_q    <= s1_mant_d;
            s1_tag_q     <= s1_tag_d;
            s1_id_q      <= s1_id_d;
            out_valid_q  <= out_valid_d;
            out_expo_q   <= out_expo_d;
            out_mant_q   <= out_mant_d;
            out_bit_s_q  <= out_bit_s_d;
            out_id_q     <= out_id_d;
            out_tag_q    <= out_tag_d;
        end
    end

    mul_lzc #(
        .IN_W  (PW),
        .OUT_W (ZERO_D)
    ) u_lzc (
        .din (s1_mant_q),
        .cnt (dp_zero_nums_c)
    );

    assign dp_expo_1 = s1_expo_q;
    assign dp_mant_1 = s1_mant_q;
    assign out_valid = out_valid_q;
    assign out_expo  = out_expo_q;
    assign out_mant  = out_mant_q;
    assign out_bit_s = out_bit_s_q;
    assign out_id    = out_id_q;
    assign out_tag   = out_tag_q;
    assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_mul_shift_arb.sv
// Directed bench for mul_shift_arb with a behavioural shift stage and a result scoreboard.
module tb_mul_shift_arb;
    import mul_pkg::*;

    typedef struct packed {
        logic       id;
        logic [3:0] tag;
        mul_norm_t  n;
    } sb_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [1:0][EXPO_W+1:0]   req_expo;
    logic [1:0][PROD_W-1:0]   req_mant;
    logic [1:0][TAG_W-1:0]    req_tag;
    logic [EXPO_W+1:0]        dp_expo_1, dp_expo_2;
    logic [PROD_W-1:0]        dp_mant_1, dp_mant_2;
    logic [ZERO_D-1:0]        dp_zero_nums_c;
    logic                     dp_bit_s;
    logic                     out_valid, out_ready, out_id, out_bit_s, busy;
    logic [TAG_W-1:0]         out_tag;
    logic [EXPO_W+1:0]        out_expo;
    logic [PROD_W-1:0]        out_mant;

    int        checks   = 0;
    int        failures = 0;
    int        hs_cnt   = 0;
    int        outs     = 0;
    logic [1:0] hs_vec;
    sb_t       q[$];

    always #5 clk = ~clk;

    mul_shift_arb dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_expo(req_expo), .req_mant(req_mant), .req_tag(req_tag),
        .dp_expo_1(dp_expo_1), .dp_mant_1(dp_mant_1), .dp_zero_nums_c(dp_zero_nums_c),
        .dp_expo_2(dp_expo_2), .dp_mant_2(dp_mant_2), .dp_bit_s(dp_bit_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_tag(out_tag), .out_expo(out_expo), .out_mant(out_mant),
        .out_bit_s(out_bit_s), .busy(busy)
    );

    // Shift stage model: MSB set -> shift right one; zero -> zero path; else shift left by lzc.
    always_comb begin
        dp_expo_2 = '0;
        dp_mant_2 = '0;
        dp_bit_s  = 1'b0;
        if (dp_zero_nums_c == 6'd48) begin
            dp_expo_2 = '0;
        end else if (dp_zero_nums_c == 6'd0) begin
            dp_expo_2 = dp_expo_1 + 10'd1;
            dp_mant_2 = dp_mant_1 >> 1;
            dp_bit_s  = dp_mant_1[0];
        end else begin
            dp_expo_2 = dp_expo_1 - {4'd0, dp_zero_nums_c};
            dp_mant_2 = dp_mant_1 << dp_zero_nums_c;
        end
    end

    function automatic int lzc_ref(input logic [47:0] m);
        for (int i = 47; i >= 0; i--) begin
            if (m[i]) return 47 - i;
        end
        return 48;
    endfunction

    function automatic mul_norm_t ref_norm(input logic [9:0] e, input logic [47:0] m);
        mul_norm_t r;
        int z;
        z = lzc_ref(m);
        r.expo = '0; r.mant = '0; r.bit_s = 1'b0;
        if (z == 0) begin
            r.expo = e + 10'd1; r.mant = m >> 1; r.bit_s = m[0];
        end else if (z != 48) begin
            r.expo = e - 10'(z); r.mant = m << z;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Falling edge: compare any completed result, then record accepted requests.
    task automatic neg();
        sb_t e;
        @(negedge clk);
        hs_vec = req_valid & req_ready;
        if (out_valid && out_ready) begin
            outs++;
            if (q.size() == 0) begin
                check("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("sb_out", {out_id, out_tag, out_expo, out_mant, out_bit_s}, 64'(e));
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (hs_vec[i]) begin
                hs_cnt++;
                e.id  = 1'(i);
                e.tag = req_tag[i];
                e.n   = ref_norm(req_expo[i], req_mant[i]);
                q.push_back(e);
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    // A requester that was accepted presents a fresh request next cycle.
    task automatic bump();
        for (int i = 0; i < 2; i++) begin
            if (hs_vec[i]) begin
                req_tag[i]  = req_tag[i] + 4'd2;
                req_mant[i] = {req_mant[i][46:0], req_mant[i][47]};
            end
        end
    endtask

    initial begin
        logic [63:0] held;
        int hs0, outs0;
        rst_n = 1'b1; flush = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
        req_expo = '0; req_mant = '0; req_tag = '0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_payload", {out_id, out_tag, out_expo, out_mant, out_bit_s}, 64'd0);
        check("rst_lzc", 64'(dp_zero_nums_c), 64'd48);
        pos(); rst_n = 1'b1; pos();

        // 1: requester 0 alone, MSB-set mantissa
        req_expo[0] = 10'd100; req_mant[0] = 48'h8000_0000_0000; req_tag[0] = 4'h3; req_valid = 2'b01;
        neg(); check("t1_ready", 64'(req_ready), 64'd1); check("t1_lat0", 64'(out_valid), 64'd0); pos();
        req_valid = 2'b00;
        neg(); check("t1_lat1", 64'(out_valid), 64'd0); pos();
        neg();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_expo", 64'(out_expo), 64'd101);
        check("t1_mant", 64'(out_mant), 64'h4000_0000_0000);
        check("t1_bit_s", 64'(out_bit_s), 64'd0);
        check("t1_id", 64'(out_id), 64'd0);
        pos();

        // 2: requester 1 alone, 23 leading zeros
        req_expo[1] = 10'd100; req_mant[1] = 48'h0000_0100_0000; req_tag[1] = 4'h5; req_valid = 2'b10;
        neg(); pos();
        req_valid = 2'b00;
        neg(); check("t2_lzc", 64'(dp_zero_nums_c), 64'd23); check("t2_expo1", 64'(dp_expo_1), 64'd100); pos();
        neg();
        check("t2_expo", 64'(out_expo), 64'd77);
        check("t2_mant", 64'(out_mant), 64'h8000_0000_0000);
        check("t2_id_tag", {59'd0, out_id, out_tag}, 64'h15);
        pos();

        // 3: both requesters for four cycles, full throughput
        req_expo[0] = 10'd200; req_mant[0] = 48'h0000_0000_0F01; req_tag[0] = 4'h0;
        req_expo[1] = 10'd300; req_mant[1] = 48'h1234_5678_9ABC; req_tag[1] = 4'h1;
        req_valid = 2'b11; outs0 = outs;
        for (int k = 0; k < 4; k++) begin
            neg(); check("t3_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2); pos(); bump();
        end
        req_valid = 2'b00;
        neg(); pos(); neg();
        check("t3_back_to_back", 64'(outs - outs0), 64'd4);
        pos();

        // 4: downstream stall with requests pending
        out_ready = 1'b0; req_valid = 2'b11; hs0 = hs_cnt; held = '0;
        for (int k = 0; k < 5; k++) begin
            neg();
            if (k >= 2) check("t4_ready_low", 64'(req_ready), 64'd0);
            if (k == 2) held = {out_id, out_tag, out_expo, out_mant, out_bit_s};
            else if (k > 2) check("t4_hold", {out_id, out_tag, out_expo, out_mant, out_bit_s}, held);
            pos(); bump();
        end
        check("t4_accepted", 64'(hs_cnt - hs0), 64'd2);
        check("t4_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1; outs0 = outs;
        neg(); pos(); bump();
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            neg(); pos();
        end
        check("t4_drain_count", 64'(outs - outs0), 64'd3);
        check("t4_drain_empty", 64'(q.size()), 64'd0);

        // 5: zero mantissa takes the zero path
        req_expo[0] = 10'd5; req_mant[0] = 48'h0; req_tag[0] = 4'h7; req_valid = 2'b01;
        neg(); pos();
        req_valid = 2'b00;
        neg(); check("t5_lzc", 64'(dp_zero_nums_c), 64'd48); pos();
        neg(); check("t5_out", {out_expo, out_mant, out_bit_s}, 64'd0); pos();

        // 6: flush with both stages occupied
        req_expo[0] = 10'd50; req_mant[0] = 48'h0000_0000_00F0; out_ready = 1'b0; req_valid = 2'b01;
        neg(); pos(); bump();
        neg(); pos(); bump();
        neg(); check("t6_busy", 64'(busy), 64'd1); check("t6_full_ready", 64'(req_ready), 64'd0); pos();
        flush = 1'b1; out_ready = 1'b1;
        neg(); check("t6_no_hs", 64'(req_ready), 64'd0); pos();
        flush = 1'b0; req_valid = 2'b00; q.delete();
        neg(); check("t6_out_valid", 64'(out_valid), 64'd0); check("t6_busy_clr", 64'(busy), 64'd0); pos();

        // Asynchronous reset in the middle of a stream
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            neg(); pos(); bump();
        end
        neg();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_payload", {out_id, out_tag, out_expo, out_mant, out_bit_s}, 64'd0);
        check("arst_s1", {6'd0, dp_expo_1, dp_mant_1}, 64'd0);
        req_valid = 2'b00; q.delete();
        pos(); rst_n = 1'b1;
        req_valid = 2'b11;
        neg(); check("arst_grant", 64'(req_ready), 64'd1); pos();
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            neg(); pos();
        end
        check("final_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
